// File: rtl/epu_pkg.sv
// Shared constants for the verify queue: check-mode codes and engine states.
package epu_pkg;

    localparam logic [1:0] MODE_SUB = 2'd0;
    localparam logic [1:0] MODE_MUL = 2'd1;
    localparam logic [1:0] MODE_XOR = 2'd2;
    localparam logic [1:0] MODE_RSV = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MUL,
        ST_CMP,
        ST_OUT
    } state_e;

endpackage

// File: rtl/epu_seq_mul.sv
// Shift-add multiplier, one multiplier bit per cycle. A start pulse latches the
// operands; KEY_W cycles later res holds the full product and done pulses once.
module epu_seq_mul #(
    parameter int KEY_W = 256
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [KEY_W-1:0]     op_a,
    input  logic [KEY_W-1:0]     op_b,
    output logic [2*KEY_W-1:0]   res,
    output logic                 done
);
    localparam int CW = $clog2(KEY_W + 1);

    logic [2*KEY_W-1:0] mcand_q;
    logic [2*KEY_W-1:0] acc_q;
    logic [KEY_W-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               run_q;
    logic               done_q;

    // Operand latch on start (ignored while running), then one add/shift per cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (run_q) begin
                if (mplier_q[0]) begin
                    acc_q <= acc_q + mcand_q;
                end
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 1'b1;
                if (cnt_q == CW'(KEY_W - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end else if (start) begin
                mcand_q  <= {{KEY_W{1'b0}}, op_a};
                mplier_q <= op_b;
                acc_q    <= '0;
                cnt_q    <= '0;
                run_q    <= 1'b1;
            end
        end
    end

    assign res  = acc_q;
    assign done = done_q;

endmodule

// File: rtl/epu_verify_queue.sv
// Buffered signature-verify engine: requests land in a small FIFO, are checked
// one at a time in arrival order, and each pass/fail returns with its tag.
module epu_verify_queue
    import epu_pkg::*;
#(
    parameter int KEY_W      = 256,
    parameter int SIG_W      = 512,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SIG_W-1:0]              in_signature,
    input  logic [KEY_W-1:0]              in_key,
    input  logic [KEY_W-1:0]              in_message,
    input  logic [1:0]                    in_mode,
    input  logic [TAG_W-1:0]              in_tag,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_result,
    output logic                          out_error,
    output logic [TAG_W-1:0]              out_tag,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [SIG_W-1:0] sig;
        logic [KEY_W-1:0] key;
        logic [KEY_W-1:0] msg;
        logic [1:0]       mode;
        logic [TAG_W-1:0] tag;
    } req_t;

    // ---------------- request FIFO ----------------
    req_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d;
    logic             push, pop, empty;

    // in_ready is the inverted full flop, so a pop never frees a slot in the same cycle.
    assign push     = in_valid && !full_q;
    assign empty    = !full_q && (wr_ptr_q == rd_ptr_q);
    assign in_ready = !full_q;
    assign level    = {full_q, PTR_W'(wr_ptr_q - rd_ptr_q)};

    // Pointer advance and full-flag tracking.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        full_d   = full_q;
        if (push && !pop && (wr_ptr_d == rd_ptr_q)) begin
            full_d = 1'b1;
        end else if (pop && !push) begin
            full_d = 1'b0;
        end
    end

    // Pointer / full registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{sig: in_signature, key: in_key, msg: in_message,
                                 mode: in_mode, tag: in_tag};
        end
    end

    // ---------------- engine ----------------
    state_e             state_q, state_d;
    req_t               work_q;
    logic               mul_start, mul_done, cmp_en;
    logic [2*KEY_W-1:0] mul_res;
    logic               unused_mul_hi;
    logic [KEY_W-1:0]   lo, hi, diff;
    logic               res_d, err_d;
    logic               res_q, err_q;
    logic [TAG_W-1:0]   tag_q;

    // Only the low half of the product takes part in the compare.
    assign unused_mul_hi = ^mul_res[2*KEY_W-1:KEY_W];

    epu_seq_mul #(.KEY_W(KEY_W)) u_mul (
        .clk    (clk),
        .resetn (resetn),
        .start  (mul_start),
        .op_a   (work_q.sig[KEY_W-1:0]),
        .op_b   (work_q.key),
        .res    (mul_res),
        .done   (mul_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!empty) state_d = ST_LOAD;
            ST_LOAD: state_d = (work_q.mode == MODE_MUL) ? ST_MUL : ST_CMP;
            ST_MUL:  if (mul_done) state_d = ST_CMP;
            ST_CMP:  state_d = ST_OUT;
            ST_OUT:  if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State-decoded controls.
    always_comb begin
        pop       = (state_q == ST_IDLE) && !empty;
        mul_start = (state_q == ST_LOAD) && (work_q.mode == MODE_MUL);
        cmp_en    = (state_q == ST_CMP);
        out_valid = (state_q == ST_OUT);
    end

    // Head of FIFO moves into the work registers on the pop edge.
    always_ff @(posedge clk) begin
        if (!resetn)  work_q <= '0;
        else if (pop) work_q <= mem_q[rd_ptr_q];
    end

    // Mode check; anything outside the three defined modes reports an error.
    always_comb begin
        lo    = work_q.sig[KEY_W-1:0];
        hi    = work_q.sig[SIG_W-1:KEY_W];
        diff  = lo - work_q.key;
        res_d = 1'b0;
        err_d = 1'b0;
        case (work_q.mode)
            MODE_SUB: res_d = (diff == work_q.msg);
            MODE_MUL: res_d = (mul_res[KEY_W-1:0] == work_q.msg);
            MODE_XOR: res_d = ((hi ^ work_q.key) == work_q.msg);
            MODE_RSV: err_d = 1'b1;
            default:  err_d = 1'b1;
        endcase
    end

    // Result registers are written only in CMP, so they hold through OUT stalls.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            res_q <= 1'b0;
            err_q <= 1'b0;
            tag_q <= '0;
        end else if (cmp_en) begin
            res_q <= res_d;
            err_q <= err_d;
            tag_q <= work_q.tag;
        end
    end

    assign out_result = res_q;
    assign out_error  = err_q;
    assign out_tag    = tag_q;
    assign busy       = (state_q != ST_IDLE) || !empty;

endmodule

// File: tb/tb_epu_verify_queue.sv
// Scoreboard bench for epu_verify_queue: stimulus pushes expected {result,error,tag}
// into a queue, an independent monitor pops and compares on every output handshake.
module tb_epu_verify_queue;
    localparam int KEY_W = 256;
    localparam int SIG_W = 512;
    localparam int D     = 4;
    localparam int TAG_W = 4;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 in_valid;
    logic                 in_ready;
    logic [SIG_W-1:0]     in_signature;
    logic [KEY_W-1:0]     in_key;
    logic [KEY_W-1:0]     in_message;
    logic [1:0]           in_mode;
    logic [TAG_W-1:0]     in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_result;
    logic                 out_error;
    logic [TAG_W-1:0]     out_tag;
    logic                 busy;
    logic [$clog2(D):0]   level;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 1;               // 0: hold low, 1: hold high, 2: random
    logic [TAG_W+1:0] exp_q[$];     // {result, error, tag}

    always #5 clk = ~clk;

    epu_verify_queue #(.KEY_W(KEY_W), .SIG_W(SIG_W), .FIFO_DEPTH(D), .TAG_W(TAG_W)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_signature(in_signature),
        .in_key(in_key), .in_message(in_message), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_error(out_error), .out_tag(out_tag), .busy(busy), .level(level)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [KEY_W-1:0] rnd_k();
        logic [KEY_W-1:0] v;
        v = '0;
        for (int i = 0; i < KEY_W / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Value the message must equal for the request to pass (mod 2^KEY_W).
    function automatic logic [KEY_W-1:0] ref_val(input logic [SIG_W-1:0] sig,
                                                 input logic [KEY_W-1:0] key,
                                                 input logic [1:0] mode);
        logic [KEY_W-1:0] lo, hi, r;
        lo = sig[KEY_W-1:0];
        hi = sig[SIG_W-1:KEY_W];
        case (mode)
            2'd0:    r = lo - key;
            2'd1:    r = lo * key;
            2'd2:    r = hi ^ key;
            default: r = '0;
        endcase
        return r;
    endfunction

    // out_ready is driven only here, away from the sampling edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rdy_mode == 2) out_ready = ($urandom_range(0, 3) != 0);
            else               out_ready = (rdy_mode == 1);
        end
    end

    // Monitor: scoreboard compare on handshake, plus hold-stability under stall.
    initial begin
        logic             pv, pr;
        logic [TAG_W+1:0] pdat, got, want;
        pv = 1'b0; pr = 1'b0; pdat = '0;
        forever begin
            @(negedge clk);
            got = {out_result, out_error, out_tag};
            if (resetn && pv && !pr) begin
                chk("stall_hold", {out_valid, got}, {1'b1, pdat});
            end
            if (resetn && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", {1'b1, got}, '0);
                end else begin
                    want = exp_q.pop_front();
                    chk("sb_result", got, want);
                end
            end
            pv = resetn && out_valid;
            pr = out_ready;
            pdat = got;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [SIG_W-1:0] sig, input logic [KEY_W-1:0] key,
                        input logic [KEY_W-1:0] msg, input logic [1:0] mode,
                        input logic [TAG_W-1:0] tag);
        int n;
        logic r;
        @(negedge clk);
        in_valid = 1'b1; in_signature = sig; in_key = key;
        in_message = msg; in_mode = mode; in_tag = tag;
        n = 0;
        while (!in_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) chk("push_timeout", 1, 0);
        r = (mode != 2'd3) && (msg == ref_val(sig, key, mode));
        exp_q.push_back({r, mode == 2'd3, tag});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || out_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", busy || out_valid, 0);
    endtask

    // Issue into an idle DUT, find the pop edge (level returns to 0), count edges to out_valid.
    task automatic run_timed(input string nm, input logic [SIG_W-1:0] sig,
                             input logic [KEY_W-1:0] key, input logic [KEY_W-1:0] msg,
                             input logic [1:0] mode, input logic [TAG_W-1:0] tag,
                             input int lat);
        int n;
        send(sig, key, msg, mode, tag);
        n = 0;
        while (level != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk({nm, "_pop"}, level, 0);
        n = 0;
        while (!out_valid && n < lat + 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, n, lat);
        wait_idle();
    endtask

    initial begin
        logic [KEY_W-1:0] ones, k, m, lo, hi;
        logic [1:0]       md;
        logic             seen;
        int               n;
        ones = '1;
        resetn = 1'b0; in_valid = 1'b0; in_signature = '0; in_key = '0;
        in_message = '0; in_mode = '0; in_tag = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        chk("rst_outs", {out_result, out_error, out_tag}, 0);
        resetn = 1'b1;

        // Directed checks with latency from the pop edge
        run_timed("sub_lat",  {{KEY_W{1'b0}}, KEY_W'(12)}, KEY_W'(5), KEY_W'(7), 2'd0, 4'd3, 2);
        run_timed("sub_lat2", {{KEY_W{1'b0}}, KEY_W'(12)}, KEY_W'(5), KEY_W'(8), 2'd0, 4'd4, 2);
        run_timed("mul_lat",  {{KEY_W{1'b0}}, KEY_W'(3)},  KEY_W'(4), KEY_W'(12), 2'd1, 4'd9, KEY_W + 3);
        run_timed("mul_wrap", {{KEY_W{1'b0}}, ones}, KEY_W'(2), ones - 1'b1, 2'd1, 4'd10, KEY_W + 3);
        run_timed("sub_wrap", '0, KEY_W'(1), ones, 2'd0, 4'd11, 2);
        run_timed("xor_lat",  {KEY_W'(8'hF0), rnd_k()}, KEY_W'(8'h0F), KEY_W'(8'hFF), 2'd2, 4'd12, 2);
        run_timed("rsv_lat",  {rnd_k(), rnd_k()}, rnd_k(), rnd_k(), 2'd3, 4'd13, 2);

        // Backpressure: the engine holds tag 0, the FIFO fills with tags 1..D
        rdy_mode = 0;
        @(posedge clk); #3;
        for (int t = 0; t <= D; t++) begin
            k = rnd_k();
            send({rnd_k(), KEY_W'(t + 20)}, k, KEY_W'(t + 20) - k, 2'd0, TAG_W'(t));
        end
        @(negedge clk);
        chk("bp_level_full", level, D);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_busy", busy, 1);
        // An extra request must wait; releasing the output must not let it bypass a full FIFO
        in_valid = 1'b1; in_signature = {rnd_k(), rnd_k()}; in_key = rnd_k();
        in_message = rnd_k(); in_mode = 2'd2; in_tag = TAG_W'(D + 1);
        repeat (4) begin
            @(negedge clk);
            chk("bp_refused", {in_ready, level}, {1'b0, ($clog2(D)+1)'(D)});
        end
        rdy_mode = 1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("no_bypass_level", level, D - 1);
        exp_q.push_back({(in_message == ref_val(in_signature, in_key, 2'd2)), 1'b0, TAG_W'(D + 1)});
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_idle();
        chk("bp_drained", exp_q.size(), 0);

        // Reset in the middle of a multiply
        k = rnd_k(); lo = rnd_k();
        send({rnd_k(), lo}, k, lo * k, 2'd1, 4'd5);
        n = 0;
        while (level != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (10) @(posedge clk);
        #1 resetn = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1 resetn = 1'b1;
        seen = 1'b0;
        repeat (KEY_W + 10) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("rst_mid_no_out", seen, 0);
        chk("rst_mid_level", level, 0);
        chk("rst_mid_busy", busy, 0);
        lo = rnd_k(); k = rnd_k();
        run_timed("post_rst_sub", {rnd_k(), lo}, k, lo - k, 2'd0, 4'd6, 2);

        // Randomised traffic with random output backpressure
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            md = 2'($urandom_range(0, 3));
            if (md == 2'd1 && $urandom_range(0, 1) == 1) md = 2'd0;
            hi = rnd_k(); lo = rnd_k(); k = rnd_k();
            if ($urandom_range(0, 1) == 1) m = ref_val({hi, lo}, k, md);
            else                           m = rnd_k();
            send({hi, lo}, k, m, md, TAG_W'($urandom()));
        end
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        chk("rand_drained", {exp_q.size() != 0, busy}, 0);
        rdy_mode = 1;
        repeat (5) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
